// File: rtl/alu_operand_stage_if.sv
// Decode-to-execute operand bus: upstream request, forwarding source, flush
// and the registered downstream operand handshake.
interface alu_operand_stage_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ERR_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [9:0]       code;
    logic [XLEN-1:0]  pc;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic             fwd_we;
    logic [4:0]       fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic             illegal;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, code, pc, rs1_addr, rs2_addr, rs1_data, rs2_data, imm,
               fwd_we, fwd_rd, fwd_data, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b, illegal, err_count
    );

    modport slave (
        input  in_valid, code, pc, rs1_addr, rs2_addr, rs1_data, rs2_data, imm,
               fwd_we, fwd_rd, fwd_data, flush, out_ready,
        output in_ready, out_valid, op_a, op_b, illegal, err_count
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-select stage: decodes the one-hot class code into ALU operands with
// single-port forwarding, captured into a valid/ready register with flush.
module alu_operand_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    alu_operand_stage_if.slave bus
);
    logic             onehot;
    logic             accept;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  a_next;
    logic [XLEN-1:0]  b_next;

    logic             valid_q;
    logic [XLEN-1:0]  op_a_q;
    logic [XLEN-1:0]  op_b_q;
    logic             illegal_q;
    logic [ERR_W-1:0] err_q;

    assign onehot = (bus.code != '0) && ((bus.code & (bus.code - 10'd1)) == '0);

    // Register x0 never takes the bypass path.
    assign rs1_val = (bus.fwd_we && bus.fwd_rd == bus.rs1_addr && bus.rs1_addr != 5'd0)
                     ? bus.fwd_data : bus.rs1_data;
    assign rs2_val = (bus.fwd_we && bus.fwd_rd == bus.rs2_addr && bus.rs2_addr != 5'd0)
                     ? bus.fwd_data : bus.rs2_data;

    always_comb begin
        a_next = '0;
        b_next = '0;
        if (onehot) begin
            if (bus.code[0] || bus.code[3]) begin
                a_next = bus.pc;
            end else if (bus.code[2]) begin
                a_next = '0;
            end else begin
                a_next = rs1_val;
            end
            b_next = (bus.code[4] || bus.code[5]) ? rs2_val : bus.imm;
        end
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            op_a_q    <= a_next;
            op_b_q    <= b_next;
            illegal_q <= !onehot;
            if (!onehot && err_q != '1) begin
                err_q <= err_q + ERR_W'(1);
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.illegal   = illegal_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(64), .ERR_W(8)) if1 ();
    alu_operand_stage_if #(.XLEN(64), .ERR_W(2)) if2 ();

    alu_operand_stage #(.XLEN(64), .ERR_W(8)) dut (.clk(clk), .reset(reset), .bus(if1));
    alu_operand_stage #(.XLEN(64), .ERR_W(2)) dut_small (.clk(clk), .reset(reset), .bus(if2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: operands chosen by instruction class name.
    function automatic void ref_ops(input logic [9:0] c, input logic [63:0] pc, imm,
                                    input logic [4:0] a1, a2, input logic [63:0] d1, d2,
                                    input logic fwe, input logic [4:0] frd, input logic [63:0] fd,
                                    output logic [63:0] a, b, output logic ill);
        int cls = -1;
        logic [63:0] r1, r2;
        a = 64'd0; b = 64'd0; ill = 1'b1;
        if ($countones(c) != 1) return;
        ill = 1'b0;
        for (int i = 0; i < 10; i++) if (c[i]) cls = i;
        r1 = (fwe && a1 != 0 && frd == a1) ? fd : d1;
        r2 = (fwe && a2 != 0 && frd == a2) ? fd : d2;
        case (cls)
            0, 3:    a = pc;  // J, AUIPC
            2:       a = 64'd0; // LUI
            default: a = r1;
        endcase
        b = (cls == 4 || cls == 5) ? r2 : imm;  // B, R
    endfunction

    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic        m_ill;
    int          m_err;

    always @(posedge clk or posedge reset) begin
        logic [63:0] a, b;
        logic ill;
        if (reset) begin
            m_valid <= 1'b0;
            m_err   <= 0;
        end else if (if1.flush) begin
            m_valid <= 1'b0;
        end else if (if1.in_valid && (!m_valid || if1.out_ready)) begin
            ref_ops(if1.code, if1.pc, if1.imm, if1.rs1_addr, if1.rs2_addr, if1.rs1_data,
                    if1.rs2_data, if1.fwd_we, if1.fwd_rd, if1.fwd_data, a, b, ill);
            m_valid <= 1'b1;
            m_a <= a; m_b <= b; m_ill <= ill;
            if (ill && m_err < 255) m_err <= m_err + 1;
        end else if (if1.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model out_valid", 64'(if1.out_valid), 64'(m_valid));
            chk("model in_ready", 64'(if1.in_ready), 64'(!m_valid || if1.out_ready));
            chk("model err_count", 64'(if1.err_count), 64'(m_err));
            if (m_valid) begin
                chk("model op_a", if1.op_a, m_a);
                chk("model op_b", if1.op_b, m_b);
                chk("model illegal", 64'(if1.illegal), 64'(m_ill));
            end
        end
    end

    task automatic set_in(input logic v, input logic [9:0] c, input logic [63:0] pc, imm,
                          input logic [4:0] a1, a2, input logic [63:0] d1, d2);
        if1.in_valid = v; if1.code = c; if1.pc = pc; if1.imm = imm;
        if1.rs1_addr = a1; if1.rs2_addr = a2; if1.rs1_data = d1; if1.rs2_data = d2;
    endtask

    localparam logic [9:0] C_R = 10'b0000100000;

    initial begin
        set_in(1'b0, 10'd0, 64'd0, 64'd0, 5'd0, 5'd0, 64'd0, 64'd0);
        if1.fwd_we = 1'b0; if1.fwd_rd = 5'd0; if1.fwd_data = 64'd0;
        if1.flush = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.code = 10'd0; if2.pc = 64'd0; if2.imm = 64'd0;
        if2.rs1_addr = 5'd0; if2.rs2_addr = 5'd0; if2.rs1_data = 64'd0; if2.rs2_data = 64'd0;
        if2.fwd_we = 1'b0; if2.fwd_rd = 5'd0; if2.fwd_data = 64'd0;
        if2.flush = 1'b0; if2.out_ready = 1'b1;

        repeat (2) tick();
        chk("reset out_valid", 64'(if1.out_valid), 64'd0);
        chk("reset in_ready", 64'(if1.in_ready), 64'd1);
        chk("reset err_count", 64'(if1.err_count), 64'd0);
        reset = 1'b0;

        set_in(1'b1, C_R, 64'h0, 64'h0, 5'd1, 5'd2, 64'd5, 64'd7);
        tick();
        chk("R out_valid", 64'(if1.out_valid), 64'd1);
        chk("R op_a", if1.op_a, 64'd5);
        chk("R op_b", if1.op_b, 64'd7);
        chk("R illegal", 64'(if1.illegal), 64'd0);

        set_in(1'b1, 10'b0000001000, 64'h1000, 64'h20, 5'd1, 5'd2, 64'd5, 64'd7);
        tick();
        chk("AUIPC op_a", if1.op_a, 64'h1000);
        chk("AUIPC op_b", if1.op_b, 64'h20);

        set_in(1'b1, 10'b0000000100, 64'h1000, 64'hABC000, 5'd1, 5'd2, 64'd5, 64'd7);
        tick();
        chk("LUI op_a", if1.op_a, 64'd0);
        chk("LUI op_b", if1.op_b, 64'hABC000);

        set_in(1'b1, C_R, 64'h0, 64'h0, 5'd3, 5'd0, 64'h11, 64'h77);
        if1.fwd_we = 1'b1; if1.fwd_rd = 5'd3; if1.fwd_data = 64'hDEAD;
        tick();
        chk("fwd op_a", if1.op_a, 64'hDEAD);
        chk("fwd op_b", if1.op_b, 64'h77);

        set_in(1'b1, C_R, 64'h0, 64'h0, 5'd0, 5'd0, 64'h11, 64'h77);
        if1.fwd_rd = 5'd0;
        tick();
        chk("x0 nobypass op_a", if1.op_a, 64'h11);
        chk("x0 nobypass op_b", if1.op_b, 64'h77);
        if1.fwd_we = 1'b0;

        set_in(1'b1, C_R, 64'h0, 64'h0, 5'd1, 5'd2, 64'hAA, 64'hBB);
        if1.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall in_ready", 64'(if1.in_ready), 64'd0);
            chk("stall out_valid", 64'(if1.out_valid), 64'd1);
            chk("stall op_a held", if1.op_a, 64'h11);
        end
        if1.out_ready = 1'b1;
        tick();
        chk("replace out_valid", 64'(if1.out_valid), 64'd1);
        chk("replace op_a", if1.op_a, 64'hAA);
        if1.in_valid = 1'b0;
        tick();
        chk("drain out_valid", 64'(if1.out_valid), 64'd0);

        set_in(1'b1, 10'd0, 64'h123, 64'h456, 5'd1, 5'd2, 64'h9, 64'h8);
        tick();
        chk("illegal0 flag", 64'(if1.illegal), 64'd1);
        chk("illegal0 op_a", if1.op_a, 64'd0);
        chk("illegal0 op_b", if1.op_b, 64'd0);
        if1.code = 10'b0000110000;
        tick();
        chk("illegal2 flag", 64'(if1.illegal), 64'd1);
        chk("illegal err_count", 64'(if1.err_count), 64'd2);

        set_in(1'b1, C_R, 64'h0, 64'h0, 5'd1, 5'd2, 64'h1, 64'h2);
        if1.out_ready = 1'b0;
        tick();
        if1.code = 10'd0; if1.flush = 1'b1;
        tick();
        chk("flush held out_valid", 64'(if1.out_valid), 64'd0);
        tick();
        chk("flush idle out_valid", 64'(if1.out_valid), 64'd0);
        chk("flush err_count", 64'(if1.err_count), 64'd2);
        if1.flush = 1'b0; if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        tick();

        for (int i = 0; i < 400; i++) begin
            logic [9:0] c;
            c = ($urandom_range(0, 7) == 0) ? 10'($urandom) : (10'd1 << $urandom_range(0, 9));
            set_in(1'($urandom_range(0, 3) != 0), c, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   {$urandom, $urandom}, {$urandom, $urandom});
            if1.fwd_we = 1'($urandom); if1.fwd_rd = 5'($urandom_range(0, 3));
            if1.fwd_data = {$urandom, $urandom};
            if1.flush = ($urandom_range(0, 15) == 0);
            if1.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        set_in(1'b1, C_R, 64'h0, 64'h0, 5'd1, 5'd2, 64'h55, 64'h66);
        if1.flush = 1'b0; if1.fwd_we = 1'b0; if1.out_ready = 1'b1;
        tick();
        if1.out_ready = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("async out_valid", 64'(if1.out_valid), 64'd0);
        chk("async op_a", if1.op_a, 64'd0);
        chk("async op_b", if1.op_b, 64'd0);
        chk("async illegal", 64'(if1.illegal), 64'd0);
        chk("async err_count", 64'(if1.err_count), 64'd0);
        chk("async in_ready", 64'(if1.in_ready), 64'd1);
        tick();
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        reset = 1'b0;

        if2.in_valid = 1'b1; if2.code = 10'd0;
        repeat (3) tick();
        chk("errw2 count3", 64'(if2.err_count), 64'd3);
        repeat (2) tick();
        chk("errw2 saturate", 64'(if2.err_count), 64'd3);
        if2.in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-select stage between decode and execute. It decodes the 10-bit one-hot instruction-class code into ALU operand A/B sources and resolves a single-port register forwarding bypass. It captures the selected XLEN-bit operands into a valid/ready pipeline register with flush, and flags and counts non-one-hot codes. It generalises the combinational operand-B select to both operands, parametrised width, forwarding, and a handshaked registered output.

## Interface
- XLEN, 64, operand/data width
- ERR_W, 8, width of saturating illegal-code counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream has a decoded instruction
- in_ready  out  1  stage can accept this cycle
- code  in  10  one-hot class: b0 J, b1 JALR, b2 LUI, b3 AUIPC, b4 B, b5 R, b6 S, b7 I-ALU, b8 LOAD, b9 CSR
- pc  in  XLEN  instruction address
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_data, rs2_data  in  XLEN each  register file read data
- imm  in  XLEN  immediate, already sign-extended
- fwd_we  in  1  forwarding source writes a register
- fwd_rd  in  5  forwarding destination index
- fwd_data  in  XLEN  forwarding value
- flush  in  1  kill the held entry and any accept this cycle
- out_valid  out  1  op_a/op_b/illegal valid
- out_ready  in  1  downstream accepts
- op_a, op_b  out  XLEN  selected operands
- illegal  out  1  captured code was not exactly one-hot
- err_count  out  ERR_W  saturating count of illegal codes accepted

## Operation
- Operand A: pc for J, AUIPC; zero for LUI; rs1 (after forwarding) for all other classes.
- Operand B: rs2 (after forwarding) for B, R; imm for all other classes, LUI included (no don't-care).
- Forwarding: rsN value = fwd_data when fwd_we and fwd_rd == rsN_addr and rsN_addr != 0; otherwise rsN_data. rsN_addr == 0 always yields rsN_data.
- Illegal: code with zero or more than one bit set; op_a = op_b = 0, illegal = 1. The transfer still occurs.
- err_count increments by 1 on each accepted illegal code, saturates at 2^ERR_W-1, and is cleared only by reset.
- Pipeline register: accept = in_valid and in_ready and not flush. On accept, op_a/op_b/illegal load and out_valid becomes 1.
- out_valid clears when out_ready drains the entry with no new accept, or when flush is asserted.
- Held outputs remain stable while out_valid and not out_ready.

## Timing
- in_ready = !out_valid || out_ready (combinational; no bubble on back-to-back transfers).
- Latency 1 cycle: inputs accepted at edge N appear at outputs after edge N.
- Forwarding compares inputs in the accept cycle; fwd_* changes after acceptance do not affect held outputs.
- Simultaneous drain and accept: the new entry replaces the old entry and out_valid stays 1.
- Flush has priority over accept and drain. After the flush edge: out_valid = 0 and err_count unchanged (a flushed illegal code is not counted).
- Reset at any time, including mid-stall: out_valid, op_a, op_b, illegal, err_count = 0 immediately, without waiting for a clock edge. in_ready is 1 while reset is asserted.

## Test plan
- R-class, code=10'b0000100000, rs1_data=5, rs2_data=7, no forwarding -> next cycle out_valid=1, op_a=5, op_b=7, illegal=0.
- AUIPC, pc=0x1000, imm=0x20 -> op_a=0x1000, op_b=0x20. LUI, imm=0xABC000 -> op_a=0, op_b=0xABC000.
- Forwarding: R-class, rs1_addr=3, rs2_addr=0, fwd_we=1, fwd_rd=3, fwd_data=0xDEAD -> op_a=0xDEAD, op_b=rs2_data. Repeat with fwd_rd=0, rs2_addr=0 -> no bypass.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs held. Then out_ready=1 with a new input -> replaced in one cycle, no bubble.
- Illegal codes 0 and 10'b0000110000 -> illegal=1, op_a=op_b=0, err_count=2. With ERR_W=2, five illegal codes -> err_count=3.
- Flush while holding an entry with in_valid=1 -> out_valid=0 next cycle and nothing accepted. Async reset mid-stall -> all outputs 0 before the next edge.
